// File: rtl/mont_precompute_if.sv
// Request/result bundle between the DSA sequencer and the Montgomery constant generator.
interface mont_precompute_if #(
    parameter int unsigned LEN = 2048
);
    logic           start;
    logic [LEN-1:0] n;
    logic [LEN-1:0] n_prime;
    logic [LEN-1:0] r2_mod_n;
    logic           busy;
    logic           done;
    logic           err;

    modport master (
        output start, n,
        input  n_prime, r2_mod_n, busy, done, err
    );

    modport slave (
        input  start, n,
        output n_prime, r2_mod_n, busy, done, err
    );
endinterface

// File: rtl/mont_precompute.sv
// Bit-serial generator of n' = -n^-1 mod 2^LEN and 2^(2*LEN) mod n for an odd modulus n.
// The inverse chain runs for the first LEN cycles, the doubling chain for all 2*LEN.
module mont_precompute #(
    parameter int unsigned LEN = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    mont_precompute_if.slave bus
);
    localparam int unsigned CntW = $clog2(2 * LEN);
    localparam logic [CntW-1:0] CntLast   = CntW'(2 * LEN - 1);
    localparam logic [CntW-1:0] CntInvEnd = CntW'(LEN);

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e          state_q, state_d;
    logic [LEN-1:0]  n_q, n_d;
    logic [LEN-1:0]  x_q, x_d;
    logic [LEN-1:0]  r_q, r_d;
    logic [LEN:0]    s_q, s_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            odd_q, odd_d;
    logic [LEN-1:0]  n_prime_q, n_prime_d;
    logic [LEN-1:0]  r2_q, r2_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [LEN:0]    s_sum;
    logic [LEN:0]    t;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            n_q       <= '0;
            x_q       <= '0;
            r_q       <= '0;
            s_q       <= '0;
            cnt_q     <= '0;
            odd_q     <= 1'b0;
            n_prime_q <= '0;
            r2_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            x_q       <= x_d;
            r_q       <= r_d;
            s_q       <= s_d;
            cnt_q     <= cnt_d;
            odd_q     <= odd_d;
            n_prime_q <= n_prime_d;
            r2_q      <= r2_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = bus.n[0] ? StCalc : StFin;
            StCalc:  if (cnt_q == CntLast) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        n_d       = n_q;
        x_d       = x_q;
        r_d       = r_q;
        s_d       = s_q;
        cnt_d     = cnt_q;
        odd_d     = odd_q;
        n_prime_d = n_prime_q;
        r2_d      = r2_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        // s <= n_q holds throughout, so the LEN+1 bit sum cannot overflow.
        s_sum     = s_q + {1'b0, n_q};
        t         = {r_q, 1'b0};
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    n_d    = bus.n;
                    s_d    = (LEN + 1)'(1);
                    x_d    = '0;
                    r_d    = (bus.n == LEN'(1)) ? '0 : LEN'(1);
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    odd_d  = bus.n[0];
                    busy_d = bus.n[0];
                end
            end
            StCalc: begin
                // x fills LSB-first by shifting in at the top; after LEN shifts bit 0 is cnt 0.
                if (cnt_q < CntInvEnd) begin
                    x_d = {s_q[0], x_q[LEN-1:1]};
                    s_d = s_q[0] ? (s_sum >> 1) : (s_q >> 1);
                end
                r_d   = (t >= {1'b0, n_q}) ? LEN'(t - {1'b0, n_q}) : t[LEN-1:0];
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) busy_d = 1'b0;
            end
            StFin: begin
                done_d    = 1'b1;
                err_d     = ~odd_q;
                n_prime_d = odd_q ? x_q : '0;
                r2_d      = odd_q ? r_q : '0;
            end
            default: ;
        endcase
    end

    assign bus.n_prime  = n_prime_q;
    assign bus.r2_mod_n = r2_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_mont_precompute.sv
// Scoreboard bench for mont_precompute at LEN=8: expected constants come from brute-force
// modular arithmetic and are checked whenever done pulses.
module tb_mont_precompute;
    localparam int unsigned LEN = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    mont_precompute_if #(.LEN(LEN)) bus ();

    mont_precompute #(.LEN(LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] np;
        logic [7:0] r2;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   done_count = 0;
    logic busy_hist [1:100];

    task automatic push_exp(input logic [7:0] nv);
        exp_t e;
        if (nv[0] == 1'b0) begin
            e.np = 8'h00; e.r2 = 8'h00; e.err = 1'b1;
        end else begin
            e.np = 8'h00;
            for (int x = 0; x < 256; x++)
                if (((int'(nv) * x + 1) % 256) == 0) e.np = 8'(x);
            e.r2  = 8'(65536 % int'(nv));
            e.err = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    // Scoreboard: every done pops one expectation; a done with nothing pending is an error.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            exp_t e;
            done_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done with np=%h r2=%h err=%b, expected none",
                         bus.n_prime, bus.r2_mod_n, bus.err);
            end else begin
                e = exp_q.pop_front();
                if ({bus.n_prime, bus.r2_mod_n, bus.err} !== {e.np, e.r2, e.err}) begin
                    errors++;
                    $display("FAIL result: got np=%h r2=%h err=%b, expected np=%h r2=%h err=%b",
                             bus.n_prime, bus.r2_mod_n, bus.err, e.np, e.r2, e.err);
                end
            end
        end
    end

    // Called just after a clock edge; returns at edge+1 time unit of the accepted-start edge.
    task automatic start_op(input logic [7:0] nv, input bit push);
        bus.n     = nv;
        bus.start = 1'b1;
        if (push) push_exp(nv);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Edges counted until done is seen; 0 means the bound expired.
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            busy_hist[k] = bus.busy;
            if (bus.done) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.n     = '0;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.n_prime, bus.r2_mod_n, bus.busy, bus.done, bus.err} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got np=%h r2=%h busy=%b done=%b err=%b, expected all 0",
                     bus.n_prime, bus.r2_mod_n, bus.busy, bus.done, bus.err);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        int cyc;
        start_op(8'hB5, 1'b1);
        wait_done(cyc);
        checks++;
        if (cyc !== 17) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, expected 17", cyc);
        end
        checks++;
        if ({busy_hist[1], busy_hist[15], bus.busy} !== 3'b110) begin
            errors++;
            $display("FAIL basic_busy: got busy@1=%b busy@15=%b busy@done=%b, expected 1 1 0",
                     busy_hist[1], busy_hist[15], bus.busy);
        end
    endtask

    task automatic test_edge_moduli();
        int cyc;
        logic [7:0] mods [2];
        mods[0] = 8'h01;
        mods[1] = 8'hFF;
        foreach (mods[i]) begin
            @(posedge clk);
            #1;
            start_op(mods[i], 1'b1);
            wait_done(cyc);
            checks++;
            if (cyc !== 17) begin
                errors++;
                $display("FAIL edge_latency n=%h: got %0d cycles, expected 17", mods[i], cyc);
            end
        end
    endtask

    task automatic test_even();
        int cyc;
        logic [7:0] mods [2];
        mods[0] = 8'h10;
        mods[1] = 8'h00;
        foreach (mods[i]) begin
            @(posedge clk);
            #1;
            start_op(mods[i], 1'b1);
            wait_done(cyc);
            checks++;
            if ({cyc == 1, busy_hist[1], bus.err} !== 3'b101) begin
                errors++;
                $display("FAIL even_path n=%h: got cycles=%0d busy=%b err=%b, expected 1 0 1",
                         mods[i], cyc, busy_hist[1], bus.err);
            end
        end
        @(posedge clk);
        #1;
        start_op(8'hB5, 1'b1);
        checks++;
        if ({bus.err, bus.busy} !== 2'b01) begin
            errors++;
            $display("FAIL err_clear: got err=%b busy=%b, expected 0 1", bus.err, bus.busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 17) begin
            errors++;
            $display("FAIL err_clear_latency: got %0d cycles, expected 17", cyc);
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        int dc0;
        @(posedge clk);
        #1;
        dc0 = done_count;
        start_op(8'hB5, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.n     = 8'h01;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(cyc);
        checks++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL ignore_latency: got %0d cycles, expected 10", cyc);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (done_count - dc0 !== 1) begin
            errors++;
            $display("FAIL ignore_single_done: got %0d dones, expected 1", done_count - dc0);
        end
    endtask

    task automatic test_abort();
        int cyc;
        int dc0;
        dc0 = done_count;
        start_op(8'hB5, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.n_prime, bus.r2_mod_n, bus.busy, bus.done, bus.err} !== 19'd0) begin
            errors++;
            $display("FAIL abort_outputs: got np=%h r2=%h busy=%b done=%b err=%b, expected all 0",
                     bus.n_prime, bus.r2_mod_n, bus.busy, bus.done, bus.err);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (done_count !== dc0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d dones, expected 0", done_count - dc0);
        end
        start_op(8'hB5, 1'b1);
        wait_done(cyc);
        checks++;
        if (cyc !== 17) begin
            errors++;
            $display("FAIL abort_restart_latency: got %0d cycles, expected 17", cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(posedge clk);
        #1;
        bus.n     = 8'hFF;
        bus.start = 1'b1;
        push_exp(8'hFF);
        push_exp(8'hFF);
        @(posedge clk);
        #1;
        wait_done(cyc);
        checks++;
        if (cyc !== 17) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d cycles, expected 17", cyc);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b done=%b, expected 1 0", bus.busy, bus.done);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 17) begin
            errors++;
            $display("FAIL b2b_second_latency: got %0d cycles, expected 17", cyc);
        end
    endtask

    task automatic test_random();
        int cyc;
        logic [7:0] nv;
        for (int i = 0; i < 8; i++) begin
            nv = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            start_op(nv, 1'b1);
            wait_done(cyc);
            checks++;
            if (cyc !== (nv[0] ? 17 : 1)) begin
                errors++;
                $display("FAIL random_latency n=%h: got %0d cycles, expected %0d",
                         nv, cyc, nv[0] ? 17 : 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edge_moduli();
        test_even();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL pending_results: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mont_precompute.md
# mont_precompute

Montgomery constant generator sitting directly upstream of the modular exponentiator in the DSA datapath. For an odd modulus `n` it computes `n_prime = -n^-1 mod 2^LEN` and `r2_mod_n = 2^(2*LEN) mod n`. These are the two constants the exponentiator consumes alongside `n`. The block is bit-serial: one add/shift and one double/subtract per clock, so the area cost is a few LEN-wide adders rather than a multiplier.

## Interface
- `LEN`, default 2048: operand width in bits; also the Montgomery radix exponent (R = 2^LEN).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request pulse, level-sampled. Accepted only in IDLE.
- `n` input LEN: modulus. Sampled only on the accepted-start edge.
- `n_prime` output LEN: `-n^-1 mod 2^LEN`. Held until the next accepted start.
- `r2_mod_n` output LEN: `2^(2*LEN) mod n`. Held until the next accepted start.
- `busy` output 1: high from the cycle after an accepted start through the last CALC cycle.
- `done` output 1: one-cycle pulse when results are valid.
- `err` output 1: set with `done` when `n` is even. Cleared on the next accepted start.

## Operation
- Reset (async, `rst_n`=0): state=IDLE. `n_prime`, `r2_mod_n`, `busy`, `done`, `err` and all internal registers go to 0.
- States: IDLE, CALC, FIN.
- **IDLE**
  - On `start`=1: latch `n` into `n_reg`, clear `err`, `cnt`=0.
  - Initialise `s` = 1 (LEN+1 bits) and `x` = 0.
  - Initialise `r` = (n==1) ? 0 : 1.
  - If `n[0]`=0, go to FIN with error; otherwise go to CALC.
- **CALC**, one iteration per cycle, `cnt` = 0 .. 2*LEN-1. Two chains run concurrently:
  - Inverse chain, only while `cnt` < LEN:
    - If `s[0]`=1: `x[cnt]`=1 and `s` = (s + n_reg) >> 1.
    - Otherwise `s` = s >> 1.
    - Invariant: n*x + 1 ≡ 0 mod 2^cnt.
    - Sum width is LEN+1 bits; no overflow, since s ≤ n_reg.
  - Doubling chain, every CALC cycle:
    - `t` = {r,1'b0} (LEN+1 bits).
    - `r` = (t >= n_reg) ? t - n_reg : t.
    - Invariant: r < n_reg.
  - After the cycle with `cnt` = 2*LEN-1, go to FIN.
- **FIN**
  - Normal path: `n_prime` = x, `r2_mod_n` = r, `done`=1, `busy`=0.
  - Error path (even `n`): `n_prime` = 0, `r2_mod_n` = 0, `err`=1, `done`=1.
  - Return to IDLE next cycle.
- `start` while `busy` or in FIN is ignored; no queuing.
- Changes on `n` after acceptance have no effect.
- `n`=0 is even, so it takes the error path.
- Reset asserted mid-CALC aborts the operation. No `done` is issued; outputs read 0.

## Timing
- Accepted start at edge T0.
  - Normal path: `busy`=1 after T0 through T0+2*LEN. `done`, `n_prime`, `r2_mod_n` update at edge T0+2*LEN+1.
  - Latency is 2*LEN+1 cycles (4097 for LEN=2048).
  - Error path: `done` and `err` at edge T0+1; `busy` never rises.
- `done` is high for exactly one cycle. `err` stays valid until the next accepted start.
- Earliest next accepted start is the edge after `done` falls; start held high continuously gives back-to-back runs with one IDLE cycle between them.
- Outputs are registered only; no combinational input-to-output paths.

## Test plan
- LEN=8, n=0xB5, pulse start -> after 17 cycles `done`=1, `n_prime`=0x63, `r2_mod_n`=0x0E, `err`=0.
- LEN=8, n=0x01 -> `n_prime`=0xFF, `r2_mod_n`=0x00; n=0xFF -> `n_prime`=0x01, `r2_mod_n`=0x01.
- LEN=8, n=0x10 -> `done`+`err` one cycle after start, `busy` stays 0, outputs 0x00. Following start with n=0xB5 clears `err`.
- LEN=8, n=0xB5, second start pulse and `n` changed to 0x01 mid-CALC -> ignored; results still 0x63/0x0E, single `done`.
- `rst_n` low at cycle 5 of CALC -> all outputs 0 immediately, no `done`. Restart with n=0xB5 gives correct result.
- LEN=2048, random odd n -> check n*n_prime+1 ≡ 0 mod 2^2048 and r2_mod_n = 2^4096 mod n against a reference model. Feed results into the exponentiator and check a^e mod n.
